code_mem_loadable: RTL and testbench

- Parametrised code memory for the YASAC CPU: DEPTH = 2^AW words of DW bits, read by the CPU fetch port, with selectable combinational or registered read.
- Adds a byte-serial program-load port (valid/ready handshake). A small FSM assembles incoming bytes into words and writes them at auto-incrementing addresses from 0.
- Lets a program be downloaded at run time instead of being fixed at elaboration.
- Sits between the control unit's PC/IR path and an external loader, e.g. a UART receiver.

---
 rtl/code_mem_loadable_if.sv | 28 ++
 rtl/code_mem_loadable.sv | 138 +++++++++++++
 tb/tb_code_mem_loadable.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_mem_loadable_if.sv
// Fetch and program-load signal bundle for code_mem_loadable.
// The master side is the CPU fetch path together with the external loader.
interface code_mem_loadable_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ld_start;
    logic [7:0]    ld_byte;
    logic          ld_valid;
    logic          ld_last;
    logic          ld_ready;
    logic          loading;
    logic          ld_done;
    logic          ld_err;
    logic [AW:0]   ld_count;

    modport master (
        output addr, ld_start, ld_byte, ld_valid, ld_last,
        input  data, ld_ready, loading, ld_done, ld_err, ld_count
    );

    modport slave (
        input  addr, ld_start, ld_byte, ld_valid, ld_last,
        output data, ld_ready, loading, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/code_mem_loadable.sv
// Code memory for the YASAC CPU with a byte-serial program-load port.
// Loaded bytes are assembled big-endian into words written from address 0 upward.
//
// state | meaning
// IDLE  | no session; fetch only, ld_ready low, ld_count/ld_err hold
// LOAD  | accepting bytes, writing each completed word at wr_addr
module code_mem_loadable #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter bit SYNC_READ = 1'b0
) (
    input logic                clk,
    input logic                reset,
    code_mem_loadable_if.slave bus
);
    localparam int BPW   = DW / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t state, state_nx;

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    logic [BCW-1:0] byte_cnt, byte_cnt_nx;
    logic [AW-1:0]  wr_addr, wr_addr_nx;
    logic [DW-1:0]  asm_word, asm_nx;
    logic [DW-1:0]  wr_word;
    logic [AW:0]    count_q, count_nx;
    logic           err_q, err_nx;
    logic           done_q, done_nx;
    logic           loading_q, ready_q;
    logic           we;
    logic           accept, word_end, addr_max;

    assign accept   = bus.ld_valid && ready_q;
    assign word_end = (byte_cnt == BCW'(BPW - 1));
    assign addr_max = &wr_addr;

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        wr_addr_nx  = wr_addr;
        asm_nx      = asm_word;
        count_nx    = count_q;
        err_nx      = err_q;
        done_nx     = 1'b0;
        we          = 1'b0;
        // Unfilled low bytes stay zero, which gives the zero-fill on an early ld_last.
        wr_word     = asm_word;
        for (int i = 0; i < BPW; i++) begin
            if (byte_cnt == BCW'(i)) wr_word[(BPW-1-i)*8 +: 8] = bus.ld_byte;
        end

        case (state)
            IDLE: begin
                if (bus.ld_start) begin
                    state_nx    = LOAD;
                    byte_cnt_nx = '0;
                    wr_addr_nx  = '0;
                    asm_nx      = '0;
                    count_nx    = '0;
                    err_nx      = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (word_end || bus.ld_last) begin
                        we          = 1'b1;
                        asm_nx      = '0;
                        byte_cnt_nx = '0;
                        count_nx    = count_q + 1'b1;
                        // Session ends on ld_last or when the top address is filled; no wrap.
                        if (bus.ld_last || addr_max) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                            err_nx   = (bus.ld_last && !word_end) || (addr_max && !bus.ld_last);
                        end else begin
                            wr_addr_nx = wr_addr + 1'b1;
                        end
                    end else begin
                        asm_nx      = wr_word;
                        byte_cnt_nx = byte_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            wr_addr   <= '0;
            asm_word  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            loading_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            byte_cnt  <= byte_cnt_nx;
            wr_addr   <= wr_addr_nx;
            asm_word  <= asm_nx;
            count_q   <= count_nx;
            err_q     <= err_nx;
            done_q    <= done_nx;
            loading_q <= (state_nx == LOAD);
            ready_q   <= (state_nx == LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (we && !reset) mem[wr_addr] <= wr_word;
    end

    generate
        if (SYNC_READ) begin : g_sync_read
            logic [DW-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (reset) rd_q <= '0;
                else       rd_q <= mem[bus.addr];
            end
            assign bus.data = rd_q;
        end else begin : g_comb_read
            assign bus.data = mem[bus.addr];
        end
    endgenerate

    assign bus.ld_ready = ready_q;
    assign bus.loading  = loading_q;
    assign bus.ld_done  = done_q;
    assign bus.ld_err   = err_q;
    assign bus.ld_count = count_q;
endmodule

// File: tb/tb_code_mem_loadable.sv
// Bench for code_mem_loadable: a combinational-read and a registered-read instance share
// one stimulus stream; session results and read data are checked from scoreboard queues.
module tb_code_mem_loadable;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int BPW   = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          ld_start = 1'b0;
    logic [7:0]    ld_byte = 8'h00;
    logic          ld_valid = 1'b0;
    logic          ld_last = 1'b0;

    always #5 clk = ~clk;

    code_mem_loadable_if #(.AW(AW), .DW(DW)) ifc0 ();
    code_mem_loadable_if #(.AW(AW), .DW(DW)) ifc1 ();

    assign ifc0.addr = addr;      assign ifc1.addr = addr;
    assign ifc0.ld_start = ld_start; assign ifc1.ld_start = ld_start;
    assign ifc0.ld_byte = ld_byte;   assign ifc1.ld_byte = ld_byte;
    assign ifc0.ld_valid = ld_valid; assign ifc1.ld_valid = ld_valid;
    assign ifc0.ld_last = ld_last;   assign ifc1.ld_last = ld_last;

    code_mem_loadable #(.AW(AW), .DW(DW), .SYNC_READ(1'b0)) u_comb (
        .clk(clk), .reset(reset), .bus(ifc0));
    code_mem_loadable #(.AW(AW), .DW(DW), .SYNC_READ(1'b1)) u_sync (
        .clk(clk), .reset(reset), .bus(ifc1));

    typedef struct packed {
        logic [AW:0] count;
        logic        err;
    } sess_t;

    sess_t         sess_q[$];
    logic [DW-1:0] rd_q[$];
    logic          rd_vld = 1'b0;
    logic [7:0]    stim_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: byte k of the stream lands in word k/BPW, big-endian; a session ends on
    // ld_last or once every word has been filled.
    task automatic model_load(input bit has_last);
        int    nb = stim_q.size();
        int    words = 0;
        bit    ended, err;
        sess_t s;
        for (int k = 0; k < nb; k++) begin
            int w = k / BPW;
            int p = k % BPW;
            if (w >= DEPTH) break;
            if (p == 0) model_mem[w] = '0;
            model_mem[w] = model_mem[w] | (DW'(stim_q[k]) << (8 * (BPW - 1 - p)));
            words = w + 1;
        end
        ended = has_last || (nb >= DEPTH * BPW);
        if (nb >= DEPTH * BPW) err = !(has_last && nb == DEPTH * BPW);
        else                   err = has_last && (nb % BPW != 0);
        if (ended) begin
            s.count = (AW + 1)'(words);
            s.err   = err;
            sess_q.push_back(s);
        end
    endtask

    task automatic fill_fixed(input logic [63:0] v, input int n);
        stim_q.delete();
        for (int k = 0; k < n; k++) stim_q.push_back(v[8*(n-1-k) +: 8]);
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom));
    endtask

    task automatic start_session();
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0;
        check("start_loading", ifc0.loading, 1);
        check("start_ready", ifc1.ld_ready, 1);
        check("start_err_clear", ifc0.ld_err, 0);
        check("start_count_clear", ifc1.ld_count, 0);
    endtask

    task automatic send_stream(input bit has_last, input bit gaps);
        int i = 0;
        int guard = 0;
        bit rdy = 1'b0;
        ld_valid = 1'b0;
        while (i < stim_q.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (ld_valid && rdy) i++;
            if (i < stim_q.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
                ld_valid = 1'b1;
                ld_byte  = stim_q[i];
                ld_last  = has_last && (i == stim_q.size() - 1);
            end else begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                ld_last  = 1'($urandom);
            end
            rdy = ifc0.ld_ready;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (guard >= 20000) begin
            chk_cnt++;
            $display("FAIL send_timeout: sent %0d of %0d bytes", i, stim_q.size());
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sess_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sess_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL done_timeout: %0d sessions pending, got no ld_done", sess_q.size());
            sess_q.delete();
        end
        check("idle_loading", ifc1.loading, 0);
    endtask

    task automatic read_words(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            addr = AW'(a);
            rd_q.push_back(model_mem[a]);
            rd_vld = 1'b1;
            @(negedge clk);
        end
        rd_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ifc0.ld_done === 1'b1 || ifc1.ld_done === 1'b1) begin
            if (sess_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: ld_done=%b/%b with no session ending",
                         ifc0.ld_done, ifc1.ld_done);
            end else begin
                sess_t e;
                e = sess_q.pop_front();
                check("done_comb", ifc0.ld_done, 1);
                check("done_sync", ifc1.ld_done, 1);
                check("count_comb", ifc0.ld_count, e.count);
                check("count_sync", ifc1.ld_count, e.count);
                check("err_comb", ifc0.ld_err, e.err);
                check("err_sync", ifc1.ld_err, e.err);
                check("done_loading", ifc0.loading, 0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_vld && rd_q.size() != 0) begin
            logic [DW-1:0] e;
            e = rd_q.pop_front();
            check("read_comb", ifc0.data, e);
            check("read_sync", ifc1.data, e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ifc0.ld_ready, 0);
        check("rst_loading", ifc1.loading, 0);
        check("rst_done", ifc0.ld_done, 0);
        check("rst_err", ifc1.ld_err, 0);
        check("rst_count", ifc0.ld_count, 0);
        check("rst_data_sync", ifc1.data, 0);
        check("rst_data_comb", ifc0.data, 0);
        reset = 1'b0;

        // Read-before-write on the registered port, and ld_start ignored inside LOAD.
        fill_fixed(64'h12345678, 4);
        model_load(1'b1);
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0; addr = '0; ld_valid = 1'b1; ld_byte = 8'h12; ld_last = 1'b0;
        @(negedge clk); ld_byte = 8'h34;
        @(negedge clk);
        check("rbw_sync_old", ifc1.data, 16'h0000);
        check("rbw_comb_new", ifc0.data, 16'h1234);
        ld_byte = 8'h56; ld_start = 1'b1;
        @(negedge clk);
        check("rbw_sync_new", ifc1.data, 16'h1234);
        ld_start = 1'b0; ld_byte = 8'h78; ld_last = 1'b1;
        @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("count_hold_idle", ifc0.ld_count, 2);
        read_words(0, 1);

        // Normal three-word load.
        start_session();
        fill_fixed(64'h123456789ABC, 6);
        model_load(1'b1);
        send_stream(1'b1, 1'b0);
        wait_idle();
        read_words(0, 3);

        // ld_last on a non-final byte: zero-filled word and sticky error.
        start_session();
        fill_fixed(64'hABCDEF, 3);
        model_load(1'b1);
        send_stream(1'b1, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        check("err_sticky", ifc1.ld_err, 1);
        read_words(0, 2);

        // Random sessions of mixed length and valid rate.
        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 40);
            start_session();
            fill_random(n);
            model_load(1'b1);
            send_stream(1'b1, 1'($urandom));
            wait_idle();
            read_words(0, (n + BPW - 1) / BPW);
        end

        // Overflow: every word filled without ld_last.
        start_session();
        stim_q.delete();
        for (int k = 0; k < DEPTH * BPW; k++) stim_q.push_back(8'h5A);
        model_load(1'b0);
        send_stream(1'b0, 1'b0);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); ld_valid = 1'b1; ld_byte = 8'hFF;
            check("ovf_ready_low", ifc0.ld_ready, 0);
        end
        @(negedge clk); ld_valid = 1'b0;
        read_words(0, DEPTH - 1);

        // Exactly full memory ending with ld_last on the final byte: no error.
        start_session();
        fill_random(DEPTH * BPW);
        model_load(1'b1);
        send_stream(1'b1, 1'b1);
        wait_idle();
        read_words(DEPTH - 4, DEPTH - 1);
        read_words(0, 3);

        // Reset in the middle of a gapped session.
        start_session();
        fill_random(3 * BPW);
        model_load(1'b0);
        send_stream(1'b0, 1'b1);
        @(negedge clk);
        check("midload_count", ifc0.ld_count, 3);
        check("midload_loading", ifc1.loading, 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_loading", ifc0.loading, 0);
        check("abort_ready", ifc1.ld_ready, 0);
        check("abort_count", ifc0.ld_count, 0);
        repeat (3) @(negedge clk);
        read_words(0, 4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
